// File: rtl/noc_bridge_pkg.sv
// Shared NoC bridge types: flit/header sizing plus serializer beat width and state encoding.
package noc_bridge_pkg;

  localparam int unsigned FlitDataSize = 64;
  localparam int unsigned SerOutWidth  = 16;

  typedef enum logic [1:0] {
    HdrReq   = 2'd0,
    HdrRsp   = 2'd1,
    HdrRdata = 2'd2,
    HdrWdata = 2'd3
  } channel_hdr_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/floo_axis_flit_serializer.sv
// Splits one wide AXIS payload into NumBeats narrow beats, LSB slice first, last beat flagged.
// Optional FLOO_SER_PARITY_EN adds a registered even-parity bit per beat.
//
// state | meaning
// IDLE  | no frame in flight, ready for a payload
// SEND  | presenting beat out_beat_idx_o of the current frame
module floo_axis_flit_serializer
  import noc_bridge_pkg::*;
#(
  parameter int unsigned InWidth  = $bits(channel_hdr_e) + FlitDataSize,
  parameter int unsigned OutWidth = SerOutWidth,
  localparam int unsigned NumBeats = (InWidth + OutWidth - 1) / OutWidth,
  localparam int unsigned CntWidth = (NumBeats > 1) ? $clog2(NumBeats) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [InWidth-1:0]  in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [OutWidth-1:0] out_data_o,
  output logic                out_last_o,
  output logic [CntWidth-1:0] out_beat_idx_o,
  output logic                out_parity_o
);

  localparam int unsigned ShWidth = NumBeats * OutWidth;

  ser_state_e          state;
  logic [ShWidth-1:0]  shreg;
  logic [ShWidth-1:0]  shifted;
  logic [ShWidth-1:0]  loaded;
  logic [CntWidth-1:0] cnt;
  logic                at_last;

  assign shifted = shreg >> OutWidth;
  assign loaded  = ShWidth'(in_data_i);
  assign at_last = (cnt == CntWidth'(NumBeats - 1));

  assign out_valid_o    = (state == SEND);
  assign out_data_o     = shreg[OutWidth-1:0];
  assign out_last_o     = (state == SEND) && at_last;
  assign out_beat_idx_o = cnt;
  // The only combinational input-to-output path: refill on the accepted last beat.
  assign in_ready_o     = (state == IDLE) || ((state == SEND) && at_last && out_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            shreg <= loaded;
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_ready_i) begin
            if (at_last) begin
              if (in_valid_i) begin
                shreg <= loaded;
                cnt   <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              shreg <= shifted;
              cnt   <= cnt + CntWidth'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FLOO_SER_PARITY_EN
  // Tracks the slice that shreg will present next, so it moves in lockstep with out_data_o.
  logic parity_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parity_q <= 1'b0;
    end else if (in_ready_o && in_valid_i) begin
      parity_q <= ^loaded[OutWidth-1:0];
    end else if ((state == SEND) && out_ready_i && !at_last) begin
      parity_q <= ^shifted[OutWidth-1:0];
    end
  end
  assign out_parity_o = parity_q;
`else
  assign out_parity_o = 1'b0;
`endif

`ifndef ignore_assert
  stable_under_backpressure : assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o) && $stable(out_last_o)
                                       && $stable(out_beat_idx_o) && $stable(out_parity_o)));
  cnt_in_range : assert property (@(posedge clk_i) disable iff (rst_i)
    (32'(cnt) < NumBeats));
  last_implies_valid : assert property (@(posedge clk_i) disable iff (rst_i)
    (out_last_o |-> out_valid_o));
`endif

endmodule

// File: tb/tb_floo_axis_flit_serializer.sv
// Scoreboard bench for floo_axis_flit_serializer: default 66->16 instance plus 66->66 and 66->64 edge widths.
module tb_floo_axis_flit_serializer;

  typedef struct {
    logic [65:0] data;
    logic        last;
    int          idx;
    logic        par;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  // default instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_out_par;
  logic [65:0] a_in_data;
  logic [15:0] a_out_data;
  logic [2:0]  a_out_idx;
  // one beat per payload
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_out_par;
  logic [65:0] b_in_data;
  logic [65:0] b_out_data;
  logic [0:0]  b_out_idx;
  // two beats per payload
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_out_par;
  logic [65:0] c_in_data;
  logic [63:0] c_out_data;
  logic [0:0]  c_out_idx;

  floo_axis_flit_serializer dut_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .out_last_o(a_out_last), .out_beat_idx_o(a_out_idx), .out_parity_o(a_out_par)
  );

  floo_axis_flit_serializer #(.InWidth(66), .OutWidth(66)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_last_o(b_out_last), .out_beat_idx_o(b_out_idx), .out_parity_o(b_out_par)
  );

  floo_axis_flit_serializer #(.InWidth(66), .OutWidth(64)) dut_c (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(c_in_valid), .in_ready_o(c_in_ready), .in_data_i(c_in_data),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_data_o(c_out_data),
    .out_last_o(c_out_last), .out_beat_idx_o(c_out_idx), .out_parity_o(c_out_par)
  );

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [65:0] data, input logic last, input int idx);
    exp_t e;
    e.data = data;
    e.last = last;
    e.idx  = idx;
`ifdef FLOO_SER_PARITY_EN
    e.par = ^data;
`else
    e.par = 1'b0;
`endif
    return e;
  endfunction

  // 66'h2_0123_4567_89AB_CDEF
  task automatic push_d1();
    qa.push_back(mk(66'hCDEF, 1'b0, 0));
    qa.push_back(mk(66'h89AB, 1'b0, 1));
    qa.push_back(mk(66'h4567, 1'b0, 2));
    qa.push_back(mk(66'h0123, 1'b0, 3));
    qa.push_back(mk(66'h0002, 1'b1, 4));
  endtask

  // 66'h1_FEDC_BA98_7654_3210
  task automatic push_d2();
    qa.push_back(mk(66'h3210, 1'b0, 0));
    qa.push_back(mk(66'h7654, 1'b0, 1));
    qa.push_back(mk(66'hBA98, 1'b0, 2));
    qa.push_back(mk(66'hFEDC, 1'b0, 3));
    qa.push_back(mk(66'h0001, 1'b1, 4));
  endtask

  task automatic compare_beat(input string tag, input exp_t e, input logic [65:0] data,
                              input logic last, input int idx, input logic par);
    check({tag, "_data"}, data, e.data);
    check({tag, "_last"}, 66'(last), 66'(e.last));
    check({tag, "_idx"}, 66'(idx), 66'(e.idx));
    check({tag, "_parity"}, 66'(par), 66'(e.par));
  endtask

  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) check("a_unexpected_beat", 66'(a_out_data), 66'h3_FFFF_FFFF_FFFF_FFFF);
      else compare_beat("a", qa.pop_front(), 66'(a_out_data), a_out_last, int'(a_out_idx), a_out_par);
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) check("b_unexpected_beat", b_out_data, ~b_out_data);
      else compare_beat("b", qb.pop_front(), b_out_data, b_out_last, int'(b_out_idx), b_out_par);
    end
  end

  always @(negedge clk) begin
    if (!rst && c_out_valid && c_out_ready) begin
      if (qc.size() == 0) check("c_unexpected_beat", 66'(c_out_data), ~66'(c_out_data));
      else compare_beat("c", qc.pop_front(), 66'(c_out_data), c_out_last, int'(c_out_idx), c_out_par);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int vcount;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_out_valid", 66'(a_out_valid), 66'd0);
    check("rst_out_last", 66'(a_out_last), 66'd0);
    check("rst_out_idx", 66'(a_out_idx), 66'd0);
    check("rst_out_data", 66'(a_out_data), 66'd0);
    check("rst_out_parity", 66'(a_out_par), 66'd0);
    check("rst_in_ready", 66'(a_in_ready), 66'd1);

    // single frame
    @(posedge clk); #1;
    push_d1();
    a_in_valid = 1'b1; a_in_data = 66'h2_0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_data = '0;
    @(negedge clk);
    check("latency_first_valid", 66'(a_out_valid), 66'd1);
    repeat (6) @(posedge clk);
    #1;
    check("single_frame_idle", 66'(a_out_valid), 66'd0);

    // back-to-back frames
    push_d1();
    a_in_valid = 1'b1; a_in_data = 66'h2_0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    push_d2();
    a_in_data = 66'h1_FEDC_BA98_7654_3210;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("b2b_valid_f1", 66'(a_out_valid), 66'd1);
      check("b2b_in_ready", 66'(a_in_ready), (k == 4) ? 66'd1 : 66'd0);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0; a_in_data = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("b2b_valid_f2", 66'(a_out_valid), 66'd1);
      @(posedge clk); #1;
    end
    check("b2b_idle_after", 66'(a_out_valid), 66'd0);

    // backpressure on beat 2
    push_d1();
    a_in_valid = 1'b1; a_in_data = 66'h2_0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_data = '0;
    vcount = 0;
    for (int c = 0; c < 12; c++) begin
      a_out_ready = !(c >= 1 && c <= 3);
      @(negedge clk);
      if (a_out_valid) vcount++;
      if (c >= 1 && c <= 4) begin
        check("bp_hold_data", 66'(a_out_data), 66'h89AB);
        check("bp_hold_idx", 66'(a_out_idx), 66'd1);
      end
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    check("bp_frame_cycles", 66'(vcount), 66'd8);

    // reset mid-frame
    qa.push_back(mk(66'hCDEF, 1'b0, 0));
    qa.push_back(mk(66'h89AB, 1'b0, 1));
    a_in_valid = 1'b1; a_in_data = 66'h2_0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 66'(a_out_valid), 66'd0);
    check("mid_rst_idx", 66'(a_out_idx), 66'd0);
    check("mid_rst_in_ready", 66'(a_in_ready), 66'd1);
    @(posedge clk); #1;
    push_d2();
    a_in_valid = 1'b1; a_in_data = 66'h1_FEDC_BA98_7654_3210;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_data = '0;
    @(negedge clk);
    check("restart_idx", 66'(a_out_idx), 66'd0);
    repeat (6) @(posedge clk);
    #1;

    // OutWidth == InWidth: register slice, full throughput
    qb.push_back(mk(66'h3_FFFF_0000_FFFF_0000, 1'b1, 0));
    qb.push_back(mk(66'h0_0000_0000_0000_0001, 1'b1, 0));
    qb.push_back(mk(66'h1_2345_6789_ABCD_EF01, 1'b1, 0));
    b_in_valid = 1'b1; b_in_data = 66'h3_FFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    b_in_data = 66'h0_0000_0000_0000_0001;
    @(negedge clk);
    check("w66_valid0", 66'(b_out_valid), 66'd1);
    check("w66_in_ready0", 66'(b_in_ready), 66'd1);
    @(posedge clk); #1;
    b_in_data = 66'h1_2345_6789_ABCD_EF01;
    @(negedge clk);
    check("w66_valid1", 66'(b_out_valid), 66'd1);
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_data = '0;
    @(negedge clk);
    check("w66_valid2", 66'(b_out_valid), 66'd1);
    @(posedge clk); #1;
    check("w66_idle", 66'(b_out_valid), 66'd0);

    // OutWidth == 64: two beats, second carries the header
    qc.push_back(mk(66'h0123_4567_89AB_CDEF, 1'b0, 0));
    qc.push_back(mk(66'h2, 1'b1, 1));
    c_in_valid = 1'b1; c_in_data = 66'h2_0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    c_in_valid = 1'b0; c_in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("w64_idle", 66'(c_out_valid), 66'd0);

    check("qa_drained", 66'(qa.size()), 66'd0);
    check("qb_drained", 66'(qb.size()), 66'd0);
    check("qc_drained", 66'(qc.size()), 66'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
